target_hash_loader: RTL and testbench
=====================================

// Module: target_hash_loader
// PURPOSE
//  Receives a 128-bit MD5 target hash from the host as a framed byte stream (UART RX byte side).
//  Drives the target register that the brute-force comparator uses, replacing a fixed hash table.
//  Validates each frame: sync byte, 16 payload bytes, then an XOR checksum byte.
//  Updates the target and pulses target_load only on a good frame.
// PARAMETERS
//  SYNC_BYTE       8'hA5     frame start marker
//  TIMEOUT_CYCLES  1000000   max CLK cycles between bytes inside a frame (10 ms @ 100 MHz); >=2
//  DEFAULT_TARGET  128'h0    target value after reset
// PORTS
//  CLK          in   1    system clock
//  reset        in   1    synchronous, active-high
//  rx_data      in   8    received byte, sampled when rx_valid=1
//  rx_valid     in   1    one-cycle strobe per received byte
//  target       out  128  current target hash, hex-string order (first payload byte = [127:120])
//  target_load  out  1    one-cycle pulse when target has been updated
//  frame_error  out  1    one-cycle pulse on checksum failure or timeout
//  error_code   out  2    00 none, 01 checksum, 10 timeout; held until next good frame
//  busy         out  1    high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset: state IDLE, target=DEFAULT_TARGET, target_load=0, frame_error=0, error_code=00,
//   busy=0, shadow/byte count/checksum/timer cleared. Reset mid-frame discards the partial frame.
//  FSM (all transitions on posedge CLK):
//   IDLE:    rx_valid & rx_data==SYNC_BYTE -> PAYLOAD (cnt=0, csum=0, timer=0); other bytes ignored.
//   PAYLOAD: on rx_valid: shadow={shadow[119:0],rx_data}, csum^=rx_data, cnt++, timer=0;
//            after 16th byte (cnt==15 on accept) -> CHECK. SYNC_BYTE value here is plain data.
//   CHECK:   on rx_valid: rx_data==csum -> target<=shadow, target_load=1, error_code=00;
//            else frame_error=1, error_code=01, target unchanged. Either way -> IDLE.
//  Timeout: in PAYLOAD/CHECK, timer increments every cycle without rx_valid; when it reaches
//   TIMEOUT_CYCLES-1 -> frame_error=1, error_code=10, -> IDLE. rx_valid in that same cycle wins (no timeout).
//  Latency: target and target_load valid the cycle after the checksum byte's rx_valid cycle.
//  target_load and frame_error are registered one-cycle pulses and never assert together.
//  Back-to-back frames: a sync byte arriving the cycle after CHECK completes is accepted.
//  Timer width: $clog2(TIMEOUT_CYCLES); byte counter 4 bits; no wrap beyond 15.
//  rx_valid assumed at most 1 cycle per byte; consecutive-cycle strobes are each a byte.
// STRUCTURE
//  Package md5_host_pkg: SYNC_BYTE default, error_code localparams (ERR_NONE/ERR_CSUM/ERR_TIMEOUT),
//   FSM state encoding, HASH_W=128.
//  Single module; the timeout counter may be a sub-module frame_timeout_timer (clear, tick, expired).
// TESTING  (bench uses TIMEOUT_CYCLES=16)
//  1. A5,00,01,...,0F,00 -> target=128'h000102030405060708090a0b0c0d0e0f, one target_load pulse.
//  2. A5, sixteen FF, 00 -> target=128'hffff...ff, error_code=00.
//  3. A5,00..0F,01 -> frame_error pulse, error_code=01, target holds value from test 1.
//  4. A5,00,01 then 16 idle cycles -> frame_error, error_code=10, busy falls; next good frame loads.
//  5. Bytes 3C,A5-less garbage in IDLE -> no pulses, busy=0; payload containing A5 loads correctly.
//  6. reset asserted after 8 payload bytes -> target=DEFAULT_TARGET, busy=0; full frame then loads.

Source files
------------

// File: rtl/md5_host_pkg.sv
// rtl/md5_host_pkg.sv - shared constants and state encoding for the host hash loader
package md5_host_pkg;

  localparam int HASH_W = 128;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } loader_state_t;

endpackage

// File: rtl/frame_timeout_timer.sv
// rtl/frame_timeout_timer.sv - inter-byte gap counter that flags a stalled frame
module frame_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_q;

  // A clear in the same cycle (byte arrived) always beats expiry.
  assign expired = tick && !clear && (count_q == LAST);

  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (tick && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/target_hash_loader.sv
// rtl/target_hash_loader.sv - framed byte-stream receiver that loads the MD5 target register
module target_hash_loader
  import md5_host_pkg::*;
#(
  parameter logic [7:0]        SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int                TIMEOUT_CYCLES = 1000000,
  parameter logic [HASH_W-1:0] DEFAULT_TARGET = '0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [HASH_W-1:0] target,
  output logic              target_load,
  output logic              frame_error,
  output logic [1:0]        error_code,
  output logic              busy
);

  loader_state_t     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [HASH_W-1:0] shadow_q, shadow_d;
  logic [HASH_W-1:0] target_q, target_d;
  logic              load_q, load_d;
  logic              ferr_q, ferr_d;
  logic [1:0]        code_q, code_d;

  logic timer_clear, timer_tick, timer_expired;

  assign timer_clear = (state_q == ST_IDLE) || rx_valid;
  assign timer_tick  = (state_q != ST_IDLE) && !rx_valid;

  frame_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (timer_clear),
    .tick   (timer_tick),
    .expired(timer_expired)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    target_d = target_q;
    load_d   = 1'b0;
    ferr_d   = 1'b0;
    code_d   = code_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_PAYLOAD;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      ST_PAYLOAD: begin
        // Sync value is ordinary data once inside the payload.
        if (rx_valid) begin
          shadow_d = {shadow_q[HASH_W-9:0], rx_data};
          csum_d   = csum_q ^ rx_data;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = ST_CHECK;
        end else if (timer_expired) begin
          ferr_d  = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            target_d = shadow_q;
            load_d   = 1'b1;
            code_d   = ERR_NONE;
          end else begin
            ferr_d = 1'b1;
            code_d = ERR_CSUM;
          end
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          ferr_d  = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      csum_q   <= '0;
      shadow_q <= '0;
      target_q <= DEFAULT_TARGET;
      load_q   <= 1'b0;
      ferr_q   <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
      target_q <= target_d;
      load_q   <= load_d;
      ferr_q   <= ferr_d;
      code_q   <= code_d;
    end
  end

  assign target      = target_q;
  assign target_load = load_q;
  assign frame_error = ferr_q;
  assign error_code  = code_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_target_hash_loader.sv
// tb/tb_target_hash_loader.sv - scoreboard bench for target_hash_loader
module tb_target_hash_loader;

  localparam int T = 16;
  localparam logic [127:0] DEF_TGT = 128'h0;

  logic         CLK = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [127:0] target;
  logic         target_load;
  logic         frame_error;
  logic [1:0]   error_code;
  logic         busy;

  target_hash_loader #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(T),
    .DEFAULT_TARGET(DEF_TGT)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .target     (target),
    .target_load(target_load),
    .frame_error(frame_error),
    .error_code (error_code),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit           is_load;
    logic [127:0] tgt;
    logic [1:0]   code;
  } ev_t;

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: frame-level view of the protocol.
  bit           m_in = 1'b0;
  logic [7:0]   m_bytes[$];
  int           m_idle = 0;
  logic [127:0] m_tgt = DEF_TGT;
  logic [1:0]   m_code = 2'b00;

  logic [7:0] pl[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit is_load, input logic [127:0] t, input logic [1:0] c);
    ev_t e;
    e.is_load = is_load;
    e.tgt = t;
    e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic model(input bit v, input logic [7:0] d, input bit rst);
    logic [7:0] x;
    logic [127:0] t;
    if (rst) begin
      m_in = 0; m_bytes.delete(); m_idle = 0; m_tgt = DEF_TGT; m_code = 2'b00;
    end else if (!m_in) begin
      if (v && d == 8'hA5) begin
        m_in = 1; m_bytes.delete(); m_idle = 0;
      end
    end else if (v) begin
      m_idle = 0;
      if (m_bytes.size() < 16) begin
        m_bytes.push_back(d);
      end else begin
        x = 8'h00;
        t = '0;
        foreach (m_bytes[i]) begin
          x = x ^ m_bytes[i];
          t = {t[119:0], m_bytes[i]};
        end
        if (d == x) begin
          m_tgt = t; m_code = 2'b00; push_ev(1'b1, m_tgt, 2'b00);
        end else begin
          m_code = 2'b01; push_ev(1'b0, m_tgt, 2'b01);
        end
        m_in = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == T) begin
        m_code = 2'b10; push_ev(1'b0, m_tgt, 2'b10); m_in = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rst);
    reset = rst; rx_valid = v; rx_data = d;
    model(v, d, rst);
    @(posedge CLK);
    #1;
    reset = 0; rx_valid = 0;
    chk("busy", 128'(busy), 128'(m_in));
    chk("error_code", 128'(error_code), 128'(m_code));
    chk("target", target, m_tgt);
    @(negedge CLK);
    #1;
    chk("pending_events", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  function automatic logic [7:0] pl_xor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 16; i++) x = x ^ pl[i];
    return x;
  endfunction

  task automatic send_frame(input logic [7:0] cs, input int maxgap);
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (maxgap > 0 && $urandom_range(0, 5) == 0) idle($urandom_range(0, maxgap));
      step(1'b1, pl[i], 1'b0);
    end
    if (maxgap > 0 && $urandom_range(0, 5) == 0) idle($urandom_range(0, maxgap));
    step(1'b1, cs, 1'b0);
  endtask

  always @(negedge CLK) begin
    ev_t e;
    if (target_load && frame_error) begin
      checks++; errors++;
      $display("FAIL pulse_overlap actual=both required=exclusive at %0t", $time);
    end
    if (target_load || frame_error) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse actual=load%0b/err%0b required=none at %0t",
                 target_load, frame_error, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 128'(target_load), 128'(e.is_load));
        chk("pulse_target", target, e.tgt);
        chk("pulse_code", 128'(error_code), 128'(e.code));
      end
    end
  end

  initial begin
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("reset_target", target, 128'h0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_code", 128'(error_code), 128'd0);
    chk("reset_pulses", 128'({target_load, frame_error}), 128'd0);

    // 1: incrementing payload
    for (int i = 0; i < 16; i++) pl[i] = 8'(i);
    send_frame(8'h00, 0);
    chk("t1_target", target, 128'h000102030405060708090a0b0c0d0e0f);
    idle(2);

    // 2: all-ones payload
    for (int i = 0; i < 16; i++) pl[i] = 8'hFF;
    send_frame(8'h00, 0);
    chk("t2_target", target, {128{1'b1}});
    chk("t2_code", 128'(error_code), 128'd0);

    // 3: bad checksum keeps the previous target
    for (int i = 0; i < 16; i++) pl[i] = 8'(i);
    send_frame(8'h00, 0);
    send_frame(8'h01, 0);
    chk("t3_code", 128'(error_code), 128'd1);
    chk("t3_target", target, 128'h000102030405060708090a0b0c0d0e0f);

    // 4: stall mid-frame, then recover; a gap one short of the limit is tolerated
    step(1'b1, 8'hA5, 1'b0); step(1'b1, 8'h00, 1'b0); step(1'b1, 8'h01, 1'b0);
    idle(T);
    chk("t4_code", 128'(error_code), 128'd2);
    chk("t4_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 16; i++) pl[i] = 8'(8'h30 + i);
    step(1'b1, 8'hA5, 1'b0);
    idle(T - 1);
    for (int i = 0; i < 16; i++) step(1'b1, pl[i], 1'b0);
    step(1'b1, pl_xor(), 1'b0);
    chk("t4_target", target, 128'h303132333435363738393a3b3c3d3e3f);

    // 5: garbage in IDLE, then a payload containing the sync value
    step(1'b1, 8'h3C, 1'b0); step(1'b1, 8'h11, 1'b0); step(1'b1, 8'h5A, 1'b0);
    chk("t5_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 16; i++) pl[i] = (i % 3 == 0) ? 8'hA5 : 8'(i);
    send_frame(pl_xor(), 0);
    chk("t5_code", 128'(error_code), 128'd0);

    // 6: reset mid-frame
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_target", target, DEF_TGT);
    chk("t6_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    send_frame(pl_xor(), 0);

    // randomized traffic
    for (int f = 0; f < 150; f++) begin
      int mode = $urandom_range(0, 9);
      for (int i = 0; i < 16; i++) pl[i] = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      if (mode <= 5) begin
        send_frame(pl_xor(), (mode == 5) ? T + 1 : 3);
      end else if (mode <= 7) begin
        send_frame(pl_xor() ^ 8'($urandom_range(1, 255)), 2);
      end else if (mode == 8) begin
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < $urandom_range(0, 16); i++) step(1'b1, pl[i], 1'b0);
        idle($urandom_range(T - 1, T + 2));
      end else begin
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, pl[i], 1'b0);
        step(1'b0, 8'h00, 1'b1);
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
    end

    idle(T + 2);
    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
